// File: rtl/vpu_lsu_sequencer.sv
// vpu_lsu_sequencer
// Vector load/store sequencer on the initiator side of the X-IF memory channel.
// It takes one strided vector memory command and issues one 32-bit request per
// element. Load results are collected in order and written to the register
// file port. Completion is reported with a one-cycle done pulse.
// Optional feature macro: VPU_LSU_ID_CHECK_EN. When it is defined, a counted
// result whose id differs from the command id sets the sticky error.
module vpu_lsu_sequencer #(
    parameter int X_ID_WIDTH      = 4,
    parameter int VLEN_WORDS      = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,

    // command from decode/execute
    input  logic                              cmd_valid_i,
    output logic                              cmd_ready_o,
    input  logic                              cmd_we_i,
    input  logic [31:0]                       cmd_base_i,
    input  logic [31:0]                       cmd_stride_i,
    input  logic [$clog2(VLEN_WORDS+1)-1:0]   cmd_len_i,
    input  logic [X_ID_WIDTH-1:0]             cmd_id_i,

    // store data read port (combinational, same cycle)
    output logic [$clog2(VLEN_WORDS)-1:0]     st_idx_o,
    input  logic [31:0]                       st_data_i,

    // load writeback port
    output logic                              ld_we_o,
    output logic [$clog2(VLEN_WORDS)-1:0]     ld_idx_o,
    output logic [31:0]                       ld_data_o,

    // X-IF mem request
    output logic                              mem_valid_o,
    input  logic                              mem_ready_i,
    output logic [31:0]                       mem_addr_o,
    output logic                              mem_we_o,
    output logic [3:0]                        mem_be_o,
    output logic [31:0]                       mem_wdata_o,
    output logic [X_ID_WIDTH-1:0]             mem_id_o,

    // X-IF mem result
    input  logic                              mem_result_valid_i,
    input  logic [31:0]                       mem_result_rdata_i,
    input  logic [X_ID_WIDTH-1:0]             mem_result_id_i,
    input  logic                              mem_result_err_i,

    // completion
    output logic                              done_valid_o,
    output logic                              done_err_o,
    output logic [X_ID_WIDTH-1:0]             done_id_o,
    output logic                              busy_o
);

    localparam int LEN_W = $clog2(VLEN_WORDS + 1);
    localparam int IDX_W = $clog2(VLEN_WORDS);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    // latched command
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [31:0]            stride_q;
    logic [LEN_W-1:0]       len_q;
    logic [X_ID_WIDTH-1:0]  id_q;
    logic                   err_q;

    // element progress
    logic [LEN_W-1:0]       issued_q;
    logic [LEN_W-1:0]       returned_q;
    logic [OUT_W-1:0]       outstanding_q;

    // registered writeback
    logic                   ld_we_q;
    logic [IDX_W-1:0]       ld_idx_q;
    logic [31:0]            ld_data_q;

    // per-cycle events
    logic                   cmd_fire;
    logic                   issue_ok;
    logic                   issue_fire;
    logic                   load_fire;
    logic                   result_fire;
    logic                   result_bad;
    logic                   last_issue;
    logic [LEN_W-1:0]       returned_d;

`ifndef VPU_LSU_ID_CHECK_EN
    // The result id is only inspected when the id check is built in.
    logic                   unused_result_id;
    assign unused_result_id = ^mem_result_id_i;
`endif

    // Handshake and result-acceptance events for this cycle.
    // NOTE: every signal written in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        cmd_fire    = (state_q == S_IDLE) && cmd_valid_i;
        // A store never waits on returns; a load may not exceed the
        // outstanding limit.
        issue_ok    = (state_q == S_ISSUE) && (issued_q < len_q) &&
                      (we_q || (outstanding_q < OUT_MAX));
        issue_fire  = issue_ok && mem_ready_i;
        load_fire   = issue_fire && !we_q;
        // A result is only meaningful while a load is in flight. That
        // includes a zero-latency return in the same cycle as its request.
        result_fire = mem_result_valid_i && !we_q &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN)) &&
                      ((outstanding_q != '0) || load_fire);
        returned_d  = result_fire ? (returned_q + LEN_ONE) : returned_q;
        last_issue  = issue_fire && ((issued_q + LEN_ONE) == len_q);
        result_bad  = mem_result_err_i;
`ifdef VPU_LSU_ID_CHECK_EN
        result_bad  = mem_result_err_i || (mem_result_id_i != id_q);
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_fire) begin
                    state_d = (cmd_len_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_issue) begin
                    if (we_q || (returned_d == len_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (returned_d == len_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode. Request fields come straight from registers, so they
    // stay put while a request is stalled on mem_ready_i.
    always_comb begin
        cmd_ready_o  = (state_q == S_IDLE);
        busy_o       = (state_q != S_IDLE);
        mem_valid_o  = issue_ok;
        mem_addr_o   = addr_q;
        mem_we_o     = we_q;
        mem_be_o     = (state_q == S_ISSUE) ? 4'hF : 4'h0;
        mem_id_o     = id_q;
        st_idx_o     = issued_q[IDX_W-1:0];
        mem_wdata_o  = ((state_q == S_ISSUE) && we_q) ? st_data_i : 32'h0;
        ld_we_o      = ld_we_q;
        ld_idx_o     = ld_idx_q;
        ld_data_o    = ld_data_q;
        done_valid_o = (state_q == S_DONE);
        done_err_o   = (state_q == S_DONE) && err_q;
        done_id_o    = (state_q == S_DONE) ? id_q : '0;
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the clock edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, address walk and element counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            we_q          <= 1'b0;
            addr_q        <= 32'h0;
            stride_q      <= 32'h0;
            len_q         <= '0;
            id_q          <= '0;
            err_q         <= 1'b0;
            issued_q      <= '0;
            returned_q    <= '0;
            outstanding_q <= '0;
        end else if (cmd_fire) begin
            we_q          <= cmd_we_i;
            addr_q        <= cmd_base_i;
            stride_q      <= cmd_stride_i;
            len_q         <= cmd_len_i;
            id_q          <= cmd_id_i;
            err_q         <= 1'b0;
            issued_q      <= '0;
            returned_q    <= '0;
            outstanding_q <= '0;
        end else begin
            if (issue_fire) begin
                issued_q <= issued_q + LEN_ONE;
                addr_q   <= addr_q + stride_q;
            end
            if (result_fire) begin
                returned_q <= returned_d;
                if (result_bad) begin
                    err_q <= 1'b1;
                end
            end
            // An issue and a return in the same cycle cancel out.
            if (load_fire && !result_fire) begin
                outstanding_q <= outstanding_q + OUT_ONE;
            end else if (!load_fire && result_fire) begin
                outstanding_q <= outstanding_q - OUT_ONE;
            end
        end
    end

    // Load writeback, registered one cycle behind the counted result.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_we_q   <= 1'b0;
            ld_idx_q  <= '0;
            ld_data_q <= 32'h0;
        end else begin
            ld_we_q <= result_fire;
            if (result_fire) begin
                ld_idx_q  <= returned_q[IDX_W-1:0];
                ld_data_q <= mem_result_rdata_i;
            end
        end
    end

endmodule
